// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU input bank: load funct3 codes, map offsets and
// a helper giving the number of bytes a load touches.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  localparam int OFS_SW    = 'h00;
  localparam int OFS_KEY   = 'h10;
  localparam int OFS_EV    = 'h14;
  localparam int MAP_BYTES = 32;

  // Bytes covered by a load; unsupported codes cover nothing.
  function automatic int unsigned access_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: return 1;
      F3_LH, F3_LHU: return 2;
      F3_LW:         return 4;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/in_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter. A new level is
// accepted only after DB_CYCLES consecutive cycles that differ from the old one.
module in_debounce #(
  parameter int W         = 4,
  parameter int DB_CYCLES = 20
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable,
  output logic [W-1:0] o_rise
);

  localparam int CW = $clog2(DB_CYCLES);

  logic [W-1:0]  r_sync1;
  logic [W-1:0]  r_sync2;
  logic [W-1:0]  r_stable;
  logic [CW-1:0] r_cnt [W];
  logic [W-1:0]  w_accept;

  // NOTE: non-blocking assignments in clocked blocks keep every flop sampling
  // pre-edge values, which is what makes the sync chain two stages deep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: the counter array is reset, not left to settle, so a reset in the
  // middle of a debounce window discards the partial count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < W; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rise is flagged in the cycle whose closing edge accepts the new high level,
  // so the event flag and the debounced level appear together.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CW'(DB_CYCLES - 1));
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_accept & r_sync2 & ~r_stable;

endmodule

// File: rtl/lsu_input_bank_dbnc.sv
// Read-only LSU peripheral bank exposing debounced switches, keypad columns and
// sticky keypad rise events (cleared by any load that covers the event byte).
module lsu_input_bank_dbnc
  import lsu_pkg::*;
#(
  parameter int SW_W      = 32,
  parameter int KEY_W     = 4,
  parameter int DB_CYCLES = 20,
  parameter int ADDR_W    = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] pi_lsu_addr,
  input  logic              penable_i,
  input  logic [2:0]        pfunct_code_i,
  input  logic [SW_W-1:0]   pwdata_i_1,
  input  logic [KEY_W-1:0]  pwdata_i_2,
  output logic [31:0]       prdata_o,
  output logic              o_key_irq
);

  // Index width wide enough that addr+3 never wraps and MAP_BYTES is representable.
  localparam int IW = ((ADDR_W > 5) ? ADDR_W : 5) + 1;

  logic [SW_W-1:0]  w_sw_stable;
  logic [SW_W-1:0]  w_sw_rise_unused;
  logic [KEY_W-1:0] w_key_stable;
  logic [KEY_W-1:0] w_key_rise;

  logic [KEY_W-1:0] r_ev;
  logic             r_irq;
  logic [KEY_W-1:0] w_ev_next;

  logic [31:0]       w_sw32;
  logic [7:0]        w_key8;
  logic [7:0]        w_ev8;
  logic [7:0]        w_byte [4];
  logic [IW-1:0]     w_idx;
  logic              w_covers_ev;
  logic              w_ev_clr;
  logic [31:0]       w_rdata;
  int unsigned       w_nbytes;

  in_debounce #(.W(SW_W), .DB_CYCLES(DB_CYCLES)) u_sw_dbnc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_raw    (pwdata_i_1),
    .o_stable (w_sw_stable),
    .o_rise   (w_sw_rise_unused)
  );

  in_debounce #(.W(KEY_W), .DB_CYCLES(DB_CYCLES)) u_key_dbnc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_raw    (pwdata_i_2),
    .o_stable (w_key_stable),
    .o_rise   (w_key_rise)
  );

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave a latch behind.
  always_comb begin
    w_sw32 = '0;
    w_key8 = '0;
    w_ev8  = '0;
    w_sw32[SW_W-1:0] = w_sw_stable;
    w_key8[KEY_W-1:0] = w_key_stable;
    w_ev8[KEY_W-1:0]  = r_ev;
  end

  // Byte gather: little-endian from addr..addr+3, no wrap past the map.
  always_comb begin
    w_nbytes    = access_bytes(pfunct_code_i);
    w_covers_ev = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx     = IW'(pi_lsu_addr) + IW'(k);
      w_byte[k] = 8'h00;
      if (w_idx < IW'(OFS_SW + 4)) begin
        w_byte[k] = w_sw32[8*w_idx[1:0] +: 8];
      end else if (w_idx == IW'(OFS_KEY)) begin
        w_byte[k] = w_key8;
      end else if (w_idx == IW'(OFS_EV)) begin
        w_byte[k] = w_ev8;
      end
      if ((k < int'(w_nbytes)) && (w_idx == IW'(OFS_EV))) w_covers_ev = 1'b1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (pfunct_code_i)
      F3_LB:   w_rdata = {{24{w_byte[0][7]}}, w_byte[0]};
      F3_LH:   w_rdata = {{16{w_byte[1][7]}}, w_byte[1], w_byte[0]};
      F3_LW:   w_rdata = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
      F3_LBU:  w_rdata = {24'h0, w_byte[0]};
      F3_LHU:  w_rdata = {16'h0, w_byte[1], w_byte[0]};
      default: w_rdata = '0;
    endcase
  end

  assign prdata_o = penable_i ? w_rdata : 32'h0;

  // Set has priority over clear-on-read so a rise coinciding with a read is kept.
  assign w_ev_clr  = penable_i && w_covers_ev;
  assign w_ev_next = (r_ev & ~{KEY_W{w_ev_clr}}) | w_key_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ev  <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ev  <= w_ev_next;
      r_irq <= |w_ev_next;
    end
  end

  assign o_key_irq = r_irq;

endmodule

// File: tb/tb_lsu_input_bank_dbnc.sv
// Directed bench for lsu_input_bank_dbnc: debounce latency, glitch rejection,
// load extension/map, clear-on-read with set priority, and mid-debounce reset.
module tb_lsu_input_bank_dbnc;

  localparam int SW_W   = 32;
  localparam int KEY_W  = 4;
  localparam int DB     = 20;
  localparam int ADDR_W = 6;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic              i_clk;
  logic              i_rst_n;
  logic [ADDR_W-1:0] pi_lsu_addr;
  logic              penable_i;
  logic [2:0]        pfunct_code_i;
  logic [SW_W-1:0]   pwdata_i_1;
  logic [KEY_W-1:0]  pwdata_i_2;
  logic [31:0]       prdata_o;
  logic              o_key_irq;

  int total = 0;
  int bad   = 0;

  lsu_input_bank_dbnc #(
    .SW_W(SW_W), .KEY_W(KEY_W), .DB_CYCLES(DB), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .pi_lsu_addr   (pi_lsu_addr),
    .penable_i     (penable_i),
    .pfunct_code_i (pfunct_code_i),
    .pwdata_i_1    (pwdata_i_1),
    .pwdata_i_2    (pwdata_i_2),
    .prdata_o      (prdata_o),
    .o_key_irq     (o_key_irq)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One load: drive, sample mid-cycle, then let exactly one edge pass.
  task automatic rd(input logic [2:0] f, input logic [ADDR_W-1:0] a, input logic en,
                    output logic [31:0] d);
    penable_i     = en;
    pfunct_code_i = f;
    pi_lsu_addr   = a;
    #3;
    d = prdata_o;
    @(posedge i_clk);
    #1;
    penable_i = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    i_rst_n       = 1'b0;
    penable_i     = 1'b0;
    pfunct_code_i = LW;
    pi_lsu_addr   = '0;
    pwdata_i_1    = '0;
    pwdata_i_2    = '0;
    tick(1);

    // Reset state
    rd(LW, 6'h00, 1'b1, d);  check("reset_sw", d, 32'h0);
    rd(LBU, 6'h10, 1'b1, d); check("reset_key", d, 32'h0);
    check("reset_irq", {31'h0, o_key_irq}, 32'h0);
    i_rst_n = 1'b1;

    // Switches: not visible one cycle early, visible at 2+DB
    pwdata_i_1 = 32'hA5C3_0F01;
    tick(DB + 1);
    rd(LW, 6'h00, 1'b1, d);  check("sw_early", d, 32'h0);
    rd(LW, 6'h00, 1'b1, d);  check("sw_lw", d, 32'hA5C3_0F01);
    rd(LB, 6'h03, 1'b1, d);  check("sw_lb3", d, 32'hFFFF_FFA5);
    rd(LH, 6'h02, 1'b1, d);  check("sw_lh2", d, 32'hFFFF_A5C3);
    rd(LHU, 6'h02, 1'b1, d); check("sw_lhu2", d, 32'h0000_A5C3);
    rd(LBU, 6'h00, 1'b1, d); check("sw_lbu0", d, 32'h0000_0001);
    rd(LW, 6'h01, 1'b1, d);  check("sw_lw_unaligned", d, 32'h00A5_C30F);
    rd(LBU, 6'h14, 1'b1, d); check("sw_no_event", d, 32'h0);
    check("sw_no_irq", {31'h0, o_key_irq}, 32'h0);

    // Unsupported funct3, disabled bank, end-of-map
    rd(3'b011, 6'h00, 1'b1, d); check("f3_011", d, 32'h0);
    rd(3'b110, 6'h00, 1'b1, d); check("f3_110", d, 32'h0);
    rd(3'b111, 6'h00, 1'b1, d); check("f3_111", d, 32'h0);
    rd(LW, 6'h00, 1'b0, d);     check("disabled", d, 32'h0);
    rd(LW, 6'h1E, 1'b1, d);     check("lw_1e", d, 32'h0);
    rd(LW, 6'h3E, 1'b1, d);     check("lw_3e", d, 32'h0);

    // Glitch of DB-1 cycles on key bit0 is rejected
    pwdata_i_2 = 4'b0001;
    tick(DB - 1);
    pwdata_i_2 = 4'b0000;
    tick(DB + 4);
    rd(LBU, 6'h10, 1'b1, d); check("glitch_key", d, 32'h0);
    rd(LBU, 6'h14, 1'b1, d); check("glitch_ev", d, 32'h0);
    check("glitch_irq", {31'h0, o_key_irq}, 32'h0);

    // Key bit2 held: level and event at 2+DB, irq, clear-on-read
    pwdata_i_2 = 4'b0100;
    tick(DB + 1);
    rd(LBU, 6'h10, 1'b1, d); check("key2_early", d, 32'h0);
    rd(LBU, 6'h10, 1'b1, d); check("key2_level", d, 32'h04);
    check("key2_irq", {31'h0, o_key_irq}, 32'h1);
    rd(LBU, 6'h14, 1'b1, d); check("key2_ev", d, 32'h04);
    rd(LBU, 6'h14, 1'b1, d); check("key2_ev_cleared", d, 32'h0);
    check("key2_irq_drop", {31'h0, o_key_irq}, 32'h0);

    // Key bit1 rise coincides with a read of the event byte: set wins
    pwdata_i_2 = 4'b0110;
    tick(DB + 1);
    rd(LBU, 6'h14, 1'b1, d); check("key1_old_flags", d, 32'h0);
    rd(LW, 6'h10, 1'b1, d);  check("key1_level", d, 32'h0000_0006);
    rd(LW, 6'h13, 1'b1, d);  check("key1_ev_kept", d, 32'h0000_0200);
    rd(LBU, 6'h14, 1'b1, d); check("key1_ev_cleared", d, 32'h0);

    // Reset in the middle of a debounce window on key bit3
    pwdata_i_2 = 4'b1110;
    tick(2 + DB / 2);
    i_rst_n = 1'b0;
    rd(LBU, 6'h10, 1'b1, d); check("rst_key", d, 32'h0);
    rd(LW, 6'h00, 1'b1, d);  check("rst_sw", d, 32'h0);
    check("rst_irq", {31'h0, o_key_irq}, 32'h0);
    i_rst_n = 1'b1;
    tick(DB + 1);
    rd(LBU, 6'h10, 1'b1, d); check("rst_key_early", d, 32'h0);
    rd(LBU, 6'h10, 1'b1, d); check("rst_key_level", d, 32'h0E);
    rd(LW, 6'h00, 1'b1, d);  check("rst_sw_level", d, 32'hA5C3_0F01);
    rd(LBU, 6'h14, 1'b1, d); check("rst_ev", d, 32'h0E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
